// File: rtl/perf_mon_pkg.sv
// Shared definitions for the pipeline run monitor.
// Holds the FSM encoding, the NOP default, the loop_len width and the per-length detection threshold.
package perf_mon_pkg;

    localparam int unsigned LOOP_LEN_W        = 3;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } perf_state_e;

    // A single-instruction loop needs 3 repeats; longer loops need two full passes.
    function automatic int unsigned loop_threshold(input int unsigned len);
        return (len == 32'd1) ? 32'd3 : 32'd2 * len;
    endfunction

endpackage

// File: rtl/perf_pc_history.sv
// PC history ring with fill tracking, plus last PC/instruction registers.
// Produces one match flag per loop length L = 1..MAX_LOOP_LEN for the current sample.
module perf_pc_history
    import perf_mon_pkg::*;
#(
    parameter int unsigned HIST_DEPTH   = 16,
    parameter int unsigned MAX_LOOP_LEN = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en_i,
    input  logic [31:0]             pc_i,
    input  logic [31:0]             instr_i,
    output logic [MAX_LOOP_LEN-1:0] match_o
);

    localparam int unsigned PTR_W  = $clog2(HIST_DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [31:0]       hist_q [HIST_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [FILL_W-1:0] fill_q;
    logic [31:0]       prev_pc_q;
    logic [31:0]       prev_instr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
            wptr_q       <= '0;
            fill_q       <= '0;
            prev_pc_q    <= '0;
            prev_instr_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) hist_q[i] <= '0;
            wptr_q       <= '0;
            fill_q       <= '0;
            prev_pc_q    <= '0;
            prev_instr_q <= '0;
        end else if (wr_en_i) begin
            hist_q[wptr_q] <= pc_i;
            wptr_q         <= wptr_q + 1'b1;
            if (fill_q != FILL_W'(HIST_DEPTH)) fill_q <= fill_q + 1'b1;
            prev_pc_q      <= pc_i;
            prev_instr_q   <= instr_i;
        end
    end

    // The fill guard keeps a PC of 0 from matching the zeroed ring right after start.
    assign match_o[0] = (fill_q != '0) && (pc_i == prev_pc_q) && (instr_i == prev_instr_q);

    genvar gi;
    generate
        for (gi = 1; gi < int'(MAX_LOOP_LEN); gi++) begin : g_match
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx      = wptr_q - PTR_W'(gi + 1);
            assign match_o[gi] = (fill_q >= FILL_W'(gi + 1)) && (pc_i == hist_q[rd_idx]);
        end
    endgenerate

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Run monitor downstream of the datapath: counts cycles/retired instructions and detects program end.
// Optional stall counter built only when PERF_STALL_CNT_EN is defined.
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int unsigned HIST_DEPTH     = 16,
    parameter int unsigned MAX_LOOP_LEN   = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           instr_in,
    input  logic                  stall_in,
    output logic                  running,
    output logic                  halted,
    output logic                  timeout,
    output logic [LOOP_LEN_W-1:0] loop_len,
    output logic [31:0]           halt_pc,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      instr_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int unsigned MCNT_W = $clog2(2 * MAX_LOOP_LEN + 1);

    perf_state_e           state_q, state_d;
    logic                  halted_q, halted_d;
    logic                  timeout_q, timeout_d;
    logic [LOOP_LEN_W-1:0] loop_len_q, loop_len_d;
    logic [31:0]           halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0]      cycle_q, cycle_d;
    logic [CNT_W-1:0]      instr_q, instr_d;

    logic                    run_en;
    logic [MAX_LOOP_LEN-1:0] match;
    logic [MAX_LOOP_LEN-1:0] hit;
    logic [LOOP_LEN_W-1:0]   hit_len;
    logic [CNT_W-1:0]        cyc_inc;
    logic                    timeout_hit;
    logic                    retire;

    assign run_en = (state_q == ST_RUN);

    perf_pc_history #(
        .HIST_DEPTH  (HIST_DEPTH),
        .MAX_LOOP_LEN(MAX_LOOP_LEN)
    ) u_hist (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .wr_en_i (run_en),
        .pc_i    (pc_in),
        .instr_i (instr_in),
        .match_o (match)
    );

    genvar gi;
    generate
        for (gi = 0; gi < int'(MAX_LOOP_LEN); gi++) begin : g_loop
            localparam int unsigned THR = loop_threshold(gi + 1);
            logic [MCNT_W-1:0] mcnt_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset)       mcnt_q <= '0;
                else if (clear)  mcnt_q <= '0;
                else if (run_en) mcnt_q <= match[gi] ? mcnt_q + 1'b1 : '0;
            end

            assign hit[gi] = match[gi] && (mcnt_q == MCNT_W'(THR - 1));
        end
    endgenerate

    assign cyc_inc     = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_inc == CNT_W'(TIMEOUT_CYCLES));
    assign retire      = (instr_in != NOP_INSTR) && !stall_in;

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        loop_len_d = loop_len_q;
        halt_pc_d  = halt_pc_q;
        cycle_d    = cycle_q;
        instr_d    = instr_q;
        hit_len    = '0;
        // Descending scan so the shortest matching loop is the one reported.
        for (int l = int'(MAX_LOOP_LEN); l >= 1; l--) begin
            if (hit[l-1]) hit_len = LOOP_LEN_W'(l);
        end
        if (clear) begin
            state_d    = ST_IDLE;
            halted_d   = 1'b0;
            timeout_d  = 1'b0;
            loop_len_d = '0;
            halt_pc_d  = '0;
            cycle_d    = '0;
            instr_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_RUN;
                ST_RUN: begin
                    cycle_d = cyc_inc;
                    if (retire && (instr_q != '1)) instr_d = instr_q + 1'b1;
                    if (hit_len != '0) begin
                        state_d    = ST_HALTED;
                        halted_d   = 1'b1;
                        loop_len_d = hit_len;
                        halt_pc_d  = pc_in;
                    end else if (timeout_hit) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            loop_len_q <= '0;
            halt_pc_q  <= '0;
            cycle_q    <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            loop_len_q <= loop_len_d;
            halt_pc_q  <= halt_pc_d;
            cycle_q    <= cycle_d;
            instr_q    <= instr_d;
        end
    end

`ifdef PERF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                     stall_q <= '0;
        else if (clear)                                stall_q <= '0;
        else if (run_en && stall_in && stall_q != '1)  stall_q <= stall_q + 1'b1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign running     = run_en;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign loop_len    = loop_len_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Scoreboard bench for pipeline_perf_monitor: expected run results are queued with each stimulus
// scenario and compared once the monitor reports its outcome.
module tb_pipeline_perf_monitor;

`ifdef PERF_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd2;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ALU = 32'h0000_0033;

    logic        clock = 1'b0;
    logic        reset, start, clear, stall_in;
    logic [31:0] pc_in, instr_in;
    logic        running, halted, timeout;
    logic [2:0]  loop_len;
    logic [31:0] halt_pc, cycle_count, instr_count, stall_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic        running;
        logic        halted;
        logic        timeout;
        logic [2:0]  loop_len;
        logic [31:0] halt_pc;
        logic [31:0] cycles;
        logic [31:0] instrs;
        logic [31:0] stalls;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    pipeline_perf_monitor #(
        .HIST_DEPTH    (16),
        .MAX_LOOP_LEN  (4),
        .CNT_W         (32),
        .TIMEOUT_CYCLES(2000),
        .NOP_INSTR     (NOP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .stall_in   (stall_in),
        .running    (running),
        .halted     (halted),
        .timeout    (timeout),
        .loop_len   (loop_len),
        .halt_pc    (halt_pc),
        .cycle_count(cycle_count),
        .instr_count(instr_count),
        .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic run, input logic h, input logic t,
                        input logic [2:0] ll, input logic [31:0] hp, input logic [31:0] cyc,
                        input logic [31:0] ins, input logic [31:0] stl);
        exp_t e;
        e.tag = tag; e.running = run; e.halted = h; e.timeout = t; e.loop_len = ll;
        e.halt_pc = hp; e.cycles = cyc; e.instrs = ins; e.stalls = stl;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        $display("[TB] %s: running=%0d halted=%0d timeout=%0d loop_len=%0d halt_pc=0x%0h cycles=%0d instrs=%0d stalls=%0d",
                 e.tag, running, halted, timeout, loop_len, halt_pc, cycle_count, instr_count, stall_count);
        check({e.tag, ".running"},  {31'd0, running},  {31'd0, e.running});
        check({e.tag, ".halted"},   {31'd0, halted},   {31'd0, e.halted});
        check({e.tag, ".timeout"},  {31'd0, timeout},  {31'd0, e.timeout});
        check({e.tag, ".loop_len"}, {29'd0, loop_len}, {29'd0, e.loop_len});
        check({e.tag, ".halt_pc"},  halt_pc,           e.halt_pc);
        check({e.tag, ".cycles"},   cycle_count,       e.cycles);
        check({e.tag, ".instrs"},   instr_count,       e.instrs);
        check({e.tag, ".stalls"},   stall_count,       e.stalls);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic stl);
        pc_in = pc; instr_in = ins; stall_in = stl;
        @(posedge clock); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    // kind 0: straight line then tight loop at 0x28; 1: 0x40/0x44 ping-pong;
    // 2: PC 0 held with NOPs; 3: straight line forever
    task automatic run_until_done(input string tag, input int kind, input int budget);
        int          n;
        logic [31:0] pc, ins;
        n = 0;
        while (!(halted || timeout) && n < budget) begin
            case (kind)
                0: begin
                    pc  = (n < 10) ? 32'(4 * n) : 32'h28;
                    ins = (n < 10) ? 32'h00A0_0093 : 32'h0000_006F;
                end
                1: begin
                    pc  = (n % 2 == 1) ? 32'h44 : 32'h40;
                    ins = ALU;
                end
                2: begin
                    pc  = 32'h0;
                    ins = NOP;
                end
                default: begin
                    pc  = 32'(4 * n);
                    ins = ALU;
                end
            endcase
            drive(pc, ins, 1'b0);
            n++;
        end
        check({tag, ".done"}, {31'd0, halted | timeout}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        pc_in = '0; instr_in = '0; stall_in = 1'b0;
        #1;
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        pop_compare();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        pulse_start();
        push("single_loop", 0, 1, 0, 3'd1, 32'h28, 32'd14, 32'd14, 32'd0);
        run_until_done("single_loop", 0, 40);
        pop_compare();

        pulse_start();
        push("start_ignored", 0, 1, 0, 3'd1, 32'h28, 32'd14, 32'd14, 32'd0);
        pop_compare();

        clear = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0; start = 1'b0;
        push("clear_and_start", 0, 0, 0, 0, 0, 0, 0, 0);
        pop_compare();
        push("stay_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(32'h80, ALU, 1'b0);
        pop_compare();

        pulse_start();
        push("two_loop", 0, 1, 0, 3'd2, 32'h44, 32'd6, 32'd6, 32'd0);
        run_until_done("two_loop", 1, 40);
        pop_compare();
        do_clear();

        pulse_start();
        push("retire", 1, 0, 0, 0, 0, 32'd10, 32'd5, EXP_STALL);
        for (int n = 0; n < 10; n++) begin
            drive(32'h100 + 32'(4 * n),
                  (n == 1 || n == 4 || n == 7) ? NOP : ALU,
                  (n == 2 || n == 8));
        end
        pop_compare();
        do_clear();

        pulse_start();
        push("history_guard", 0, 1, 0, 3'd1, 32'h0, 32'd4, 32'd0, 32'd0);
        run_until_done("history_guard", 2, 20);
        pop_compare();
        do_clear();

        pulse_start();
        push("timeout", 0, 0, 1, 0, 0, 32'd2000, 32'd2000, 32'd0);
        run_until_done("timeout", 3, 2100);
        pop_compare();
        push("timeout_frozen", 0, 0, 1, 0, 0, 32'd2000, 32'd2000, 32'd0);
        for (int n = 0; n < 5; n++) drive(32'h40, ALU, 1'b1);
        pop_compare();
        do_clear();

        pulse_start();
        for (int n = 0; n < 3; n++) drive(32'h200 + 32'(4 * n), ALU, 1'b0);
        push("pre_reset_run", 1, 0, 0, 0, 0, 32'd3, 32'd3, 32'd0);
        pop_compare();
        #2 reset = 1'b1;
        #1;
        push("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        pop_compare();
        #3 reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
Synthesizable run monitor that sits directly downstream of `datapath` and consumes its debug outputs: `pc_current`, `instruction_current` and `stall_debug`.
- Counts cycles and retired (non-NOP, non-stalled) instructions.
- Detects program end: a tight loop of 1–4 instructions, or a cycle timeout.
- Freezes statistics and reports the halt PC and loop length for SoC-level status registers and self-checking simulation.

Parameters:
- HIST_DEPTH, 16: PC history ring depth; power of two, must be ≥ MAX_LOOP_LEN.
- MAX_LOOP_LEN, 4: longest loop length L that is detected (1..MAX_LOOP_LEN).
- CNT_W, 32: width of all counters.
- TIMEOUT_CYCLES, 2000: RUN cycles before timeout is declared; 0 disables timeout.
- NOP_INSTR, 32'h00000013: encoding excluded from instr_count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; moves IDLE to RUN.
- clear  in  1  synchronous; returns to IDLE and zeroes all state.
- pc_in  in  32  pc_current from datapath.
- instr_in  in  32  instruction_current from datapath.
- stall_in  in  1  stall_debug from datapath.
- running  out  1  state == RUN.
- halted  out  1  loop detected (sticky until clear/reset).
- timeout  out  1  timeout reached (sticky until clear/reset).
- loop_len  out  3  detected loop length 1..4; 0 if none.
- halt_pc  out  32  pc_in sampled on the detecting edge.
- cycle_count  out  CNT_W  RUN cycles sampled.
- instr_count  out  CNT_W  retired instructions.
- stall_count  out  CNT_W  stalled cycles (see Optional Feature).

Behaviour:
- Reset (async) and clear: state=IDLE, every output 0, history and match counters 0, fill=0.
- clear has priority over start in the same cycle.
- FSM states: IDLE, RUN, HALTED, TIMEOUT.
  - IDLE→RUN on start.
  - RUN→HALTED on loop detect.
  - RUN→TIMEOUT when cycle_count reaches TIMEOUT_CYCLES.
  - HALTED and TIMEOUT are terminal until clear.
  - start is ignored outside IDLE.
- Every RUN edge:
  - cycle_count += 1.
  - instr_count += 1 iff instr_in != NOP_INSTR and !stall_in.
  - pc_in is written into the history ring; write pointer wraps modulo HIST_DEPTH.
  - fill saturates at HIST_DEPTH.
- Counters saturate at all-ones and do not wrap.
- Loop match rule, per L:
  - L=1 matches when pc_in == previous PC and instr_in == previous instruction.
  - L≥2 matches when pc_in == PC sampled L cycles earlier.
  - A comparison is valid only when fill ≥ L. This prevents a false match of PC 0 against the zeroed history.
- Per-L match counter: increments on a match, resets to 0 on a mismatch.
- Thresholds: L=1 needs 3; L≥2 needs 2·L (L=2:4, L=3:6, L=4:8).
- Detect edge:
  - Counter reaching its threshold moves RUN→HALTED on that edge.
  - halt_pc=pc_in, loop_len=L; visible the cycle after.
  - If several L reach threshold on the same edge, report the smallest L.
- Halt detect and timeout on the same edge: halt wins; timeout stays 0.
- Counters, cycle_count and instr_count freeze outside RUN; the sample on the detecting edge is counted.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs 0.
- Latency: one register stage from inputs to every output.

Optional Feature:
- Macro PERF_STALL_CNT_EN, defined: stall_count increments on RUN edges with stall_in=1, saturating and frozen like the other counters.
- Not defined: stall_count is tied to 0 and no counter logic is built. The port is always present.

Decomposition:
- Package perf_mon_pkg holds:
  - the FSM state encoding (IDLE=0, RUN=1, HALTED=2, TIMEOUT=3);
  - the NOP_INSTR default;
  - the per-L threshold function;
  - the loop_len width constant.
- Sub-module perf_pc_history holds:
  - the HIST_DEPTH ring, write pointer and fill counter;
  - previous PC/instruction registers;
  - per-L "match valid" outputs.
- The top level keeps the FSM, the counters and the priority encoder.

Test Plan:
- Single loop: start, then PCs 0x00,0x04,…,0x24, then 0x28 with instr 0x0000006F held → halted after the 4th 0x28 sample; loop_len=1, halt_pc=0x28, cycle_count=14.
- Two-instruction loop: PCs alternating 0x40,0x44 from start → halted on the 6th sample; loop_len=2, halt_pc=0x44. The L=4 detector must not win.
- Retire count: 10 RUN cycles, 3 of them instr=0x00000013, 2 other cycles with stall_in=1 → cycle_count=10, instr_count=5. stall_count=2 with PERF_STALL_CNT_EN defined, else 0.
- Timeout: linear PCs 0x00+4n, TIMEOUT_CYCLES=2000 → timeout=1, halted=0, cycle_count=2000, state frozen thereafter.
- History guard: start with pc_in=0x00000000 held, instr 0x00000013 → no L≥2 match before fill≥L; halted with loop_len=1 after 3 matches (4th sample).
- Reset/clear: assert reset mid-RUN → all outputs 0 asynchronously. Assert clear+start together in HALTED → IDLE, counters 0, running=0.
